// File: rtl/fpmul_share_pkg.sv
// Shared types and helpers for the FP multiplier sharing arbiter.
package fpmul_share_pkg;

  localparam int unsigned FP_W     = 32;
  // Upper bounds so the tag and pick types stay fixed-width for any legal NREQ.
  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned MAX_IDW  = 3;
  localparam int unsigned CAND_W   = MAX_IDW + 1;

  typedef struct packed {
    logic               v;
    logic [MAX_IDW-1:0] id;
  } tag_t;

  typedef struct packed {
    logic               found;
    logic [MAX_IDW-1:0] idx;
  } pick_t;

  // Round-robin pick: first set bit of req scanning from ptr+1 upward, wrapping at nreq.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                    input logic [MAX_IDW-1:0]  ptr,
                                    input int unsigned         nreq);
    pick_t             res;
    logic [CAND_W-1:0] cand;
    res = '0;
    for (int unsigned off = 1; off <= MAX_NREQ; off++) begin
      cand = {1'b0, ptr} + CAND_W'(off);
      if (cand >= CAND_W'(nreq)) cand = cand - CAND_W'(nreq);
      if (off <= nreq && !res.found && req[cand[MAX_IDW-1:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[MAX_IDW-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fpmul_share_arb_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant plus last-winner pointer.
module rr_arbiter
  import fpmul_share_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_vld
);

  logic [IDW-1:0]      ptr;
  logic [MAX_NREQ-1:0] req_ext;
  logic [MAX_IDW-1:0]  ptr_ext;
  pick_t               pick;

  // Priority pick starting just after the previous winner.
  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req;
    ptr_ext             = '0;
    ptr_ext[IDW-1:0]    = ptr;
    pick                = rr_pick(req_ext, ptr_ext, NREQ);
    grant_vld           = en & pick.found;
    grant_idx           = pick.idx[IDW-1:0];
    grant               = '0;
    if (grant_vld) grant[grant_idx] = 1'b1;
  end

  // Pointer resets to NREQ-1 so requester 0 wins first; moves only on a grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= IDW'(NREQ - 1);
    end else if (grant_vld) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/fpmul_share_arb.sv
// Shares one pipelined FP multiplier among NREQ requesters with tag-based result routing.
module fpmul_share_arb
  import fpmul_share_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MUL_LAT = 8,
  parameter int unsigned IDW     = 2,
  parameter int unsigned CNTW    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*FP_W-1:0] req_a,
  input  logic [NREQ*FP_W-1:0] req_b,
  output logic                 mul_valid,
  output logic [FP_W-1:0]      mul_a,
  output logic [FP_W-1:0]      mul_b,
  input  logic                 mul_res_valid,
  input  logic [FP_W-1:0]      mul_res,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]      rsp_data,
  output logic [IDW-1:0]       rsp_id,
  output logic                 busy,
  output logic [CNTW-1:0]      issued_cnt,
  output logic                 err
);

  localparam int unsigned DRW = $clog2(MUL_LAT + 2);

  logic [DRW-1:0]  drain;
  logic            arb_en;
  logic            xfer;
  logic [IDW-1:0]  gidx;
  logic [FP_W-1:0] sel_a;
  logic [FP_W-1:0] sel_b;
  logic [IDW-1:0]  mul_id;
  tag_t            stage [MUL_LAT];
  logic [IDW-1:0]  last_id;

  // Results emerging while draining may belong to pre-reset work, so grants wait too.
  assign arb_en  = en & (drain == '0);
  assign last_id = stage[MUL_LAT-1].id[IDW-1:0];

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (arb_en),
    .req       (req_valid),
    .grant     (req_ready),
    .grant_idx (gidx),
    .grant_vld (xfer)
  );

  // Operand mux for the winning requester.
  always_comb begin
    sel_a = req_a[gidx*FP_W +: FP_W];
    sel_b = req_b[gidx*FP_W +: FP_W];
  end

  // Multiplier input register; operands hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mul_valid  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_id     <= '0;
      issued_cnt <= '0;
    end else begin
      mul_valid <= xfer;
      if (xfer) begin
        mul_a      <= sel_a;
        mul_b      <= sel_b;
        mul_id     <= gidx;
        issued_cnt <= issued_cnt + CNTW'(1);
      end
    end
  end

  // Tag pipe runs alongside the multiplier; last stage lines up with mul_res_valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MUL_LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= '{v: mul_valid, id: MAX_IDW'(mul_id)};
      for (int i = 1; i < MUL_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  // Busy whenever anything sits in the input register or the tag pipe.
  always_comb begin
    busy = mul_valid;
    for (int i = 0; i < MUL_LAT; i++) busy = busy | stage[i].v;
  end

  // Post-reset drain counter covering the multiplier's un-reset pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain <= DRW'(MUL_LAT + 1);
    end else if (drain != '0) begin
      drain <= drain - DRW'(1);
    end
  end

  // Response routing and sticky tag/result consistency check.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= '0;
      if (drain == '0) begin
        if (mul_res_valid != stage[MUL_LAT-1].v) err <= 1'b1;
        if (mul_res_valid && stage[MUL_LAT-1].v) begin
          rsp_valid[last_id] <= 1'b1;
          rsp_data           <= mul_res;
          rsp_id             <= last_id;
        end
      end
    end
  end

endmodule
